asphalt_spi_slave: RTL and testbench

SPI slave peripheral for the Asphalt system: the far end of the 8-bit SPI master link (mode 0: CPOL=0, CPHA=0; MSB first). It oversamples the external SCLK/SS_n/MOSI lines in the 50 MHz system clock domain, shifts a byte in and out per frame, and exposes holding registers, status and interrupt through the same two-cycle CPU register port style used by the Asphalt SPI master.

---
 rtl/asphalt_spi_slave.sv | 173 +++++++++++++++++
 tb/tb_asphalt_spi_slave.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/asphalt_spi_slave.sv
// SPI mode-0 slave for the Asphalt link: oversamples SCLK/SS_n/MOSI in the clk domain,
// shifts one byte each way per frame and exposes rx/tx holding, status, control and irq.
module asphalt_spi_slave (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        SCLK,
  input  logic        SS_n,
  input  logic        MOSI,
  output logic        MISO,
  input  logic        spi_select,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [2:0]  mem_addr,
  input  logic [15:0] data_from_cpu,
  output logic [15:0] data_to_cpu,
  output logic        irq,
  output logic        dataavailable,
  output logic        readyfordata
);

  localparam int SYNC_STAGES = 2;

  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
  logic       sclk_d, ss_d;
  logic       sclk_s, ss_s, mosi_s;
  logic       active, sclk_rise, sclk_fall, ss_fall, ss_rise, tx_load;

  logic [2:0] bit_cnt;
  logic [6:0] shift_rx;
  logic [7:0] shift_tx, rx_byte, rx_holding, tx_holding;
  logic       rx_done, primed;
  logic       roe, toe, rrdy, trdy, tmt, err;
  logic       i_roe, i_toe, i_trdy, i_rrdy, i_e;
  logic       rd_prev, wr_prev, rd_stb, wr_stb;
  logic       rd_rx, wr_tx, wr_status, wr_ctrl;
  logic [15:0] status_word, ctrl_word, rd_mux;
  logic       unused;

  // Select idles high so a reset never fakes a slave-select falling edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      ss_d      <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      sclk_d    <= sclk_s;
      ss_d      <= ss_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign active    = ~ss_s;
  assign sclk_rise = active & sclk_s & ~sclk_d;
  assign sclk_fall = active & ~sclk_s & sclk_d;
  assign ss_fall   = ~ss_s & ss_d;
  assign ss_rise   = ss_s & ~ss_d;
  assign tx_load   = ss_fall | (sclk_fall & (bit_cnt == 3'd0));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt  <= 3'd0;
      shift_rx <= 7'd0;
      shift_tx <= 8'd0;
      rx_byte  <= 8'd0;
      rx_done  <= 1'b0;
      MISO     <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      if (ss_fall) begin
        bit_cnt  <= 3'd0;
        shift_rx <= 7'd0;
      end else if (ss_rise) begin
        bit_cnt <= 3'd0;
      end else if (sclk_rise) begin
        shift_rx <= {shift_rx[5:0], mosi_s};
        bit_cnt  <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          rx_byte <= {shift_rx, mosi_s};
          rx_done <= 1'b1;
        end
      end
      // An unprimed load sends zeros (underrun) without raising a flag.
      if (tx_load)        shift_tx <= primed ? tx_holding : 8'h00;
      else if (sclk_fall) shift_tx <= {shift_tx[6:0], 1'b0};
      MISO <= shift_tx[7] & active;
    end
  end

  // Each access strobes once, on the first cycle the select/strobe pair is seen.
  assign rd_stb    = spi_select & ~read_n & ~rd_prev;
  assign wr_stb    = spi_select & ~write_n & ~wr_prev;
  assign rd_rx     = rd_stb & (mem_addr == 3'd0);
  assign wr_tx     = wr_stb & (mem_addr == 3'd1);
  assign wr_status = wr_stb & (mem_addr == 3'd2);
  assign wr_ctrl   = wr_stb & (mem_addr == 3'd3);

  assign trdy = ~primed;
  assign tmt  = ~primed & ~active;
  assign err  = roe | toe;
  assign status_word = {7'd0, err, rrdy, trdy, tmt, toe, roe, 3'd0};
  assign ctrl_word   = {7'd0, i_e, i_rrdy, i_trdy, 1'b0, i_toe, i_roe, 3'd0};

  always_comb begin
    rd_mux = 16'd0;
    case (mem_addr)
      3'd0:    rd_mux = {8'd0, rx_holding};
      3'd2:    rd_mux = status_word;
      3'd3:    rd_mux = ctrl_word;
      default: rd_mux = 16'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_prev     <= 1'b0;
      wr_prev     <= 1'b0;
      tx_holding  <= 8'd0;
      rx_holding  <= 8'd0;
      primed      <= 1'b0;
      roe         <= 1'b0;
      toe         <= 1'b0;
      rrdy        <= 1'b0;
      {i_e, i_rrdy, i_trdy, i_toe, i_roe} <= 5'd0;
      data_to_cpu <= 16'd0;
      irq         <= 1'b0;
    end else begin
      rd_prev     <= spi_select & ~read_n;
      wr_prev     <= spi_select & ~write_n;
      data_to_cpu <= rd_mux;

      // The later write-prime overrides the load-clear when both land together.
      if (tx_load) primed <= 1'b0;
      if (wr_tx && !primed) begin
        tx_holding <= data_from_cpu[7:0];
        primed     <= 1'b1;
      end

      if (wr_tx && primed) toe <= 1'b1;
      else if (wr_status)  toe <= 1'b0;

      if (rx_done && rrdy) roe <= 1'b1;
      else if (wr_status)  roe <= 1'b0;

      if (rx_done)                  rrdy <= 1'b1;
      else if (rd_rx || wr_status)  rrdy <= 1'b0;

      if (rx_done) rx_holding <= rx_byte;

      if (wr_ctrl) begin
        i_roe  <= data_from_cpu[3];
        i_toe  <= data_from_cpu[4];
        i_trdy <= data_from_cpu[6];
        i_rrdy <= data_from_cpu[7];
        i_e    <= data_from_cpu[8];
      end

      irq <= (roe & i_roe) | (toe & i_toe) | (trdy & i_trdy) | (rrdy & i_rrdy) | (err & i_e);
    end
  end

  assign dataavailable = rrdy;
  assign readyfordata  = trdy;
  assign unused = &{1'b0, data_from_cpu[15:9], data_from_cpu[5], data_from_cpu[2:0]};

endmodule

// File: tb/tb_asphalt_spi_slave.sv
// Directed bench for asphalt_spi_slave: a bit-banged SPI mode-0 master plus CPU
// register accesses, checking received bytes, register reads and flag outputs.
module tb_asphalt_spi_slave;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        SCLK = 1'b0;
  logic        SS_n = 1'b1;
  logic        MOSI = 1'b0;
  logic        MISO;
  logic        spi_select = 1'b0;
  logic        read_n = 1'b1;
  logic        write_n = 1'b1;
  logic [2:0]  mem_addr = 3'd0;
  logic [15:0] data_from_cpu = 16'd0;
  logic [15:0] data_to_cpu;
  logic        irq, dataavailable, readyfordata;

  int passed = 0;
  int total  = 0;

  asphalt_spi_slave dut (
    .clk(clk), .reset_n(reset_n), .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
    .spi_select(spi_select), .read_n(read_n), .write_n(write_n), .mem_addr(mem_addr),
    .data_from_cpu(data_from_cpu), .data_to_cpu(data_to_cpu), .irq(irq),
    .dataavailable(dataavailable), .readyfordata(readyfordata)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic cpu_write(input logic [2:0] addr, input logic [15:0] data);
    @(negedge clk);
    spi_select = 1'b1; write_n = 1'b0; mem_addr = addr; data_from_cpu = data;
    @(negedge clk);
    @(negedge clk);
    spi_select = 1'b0; write_n = 1'b1;
  endtask

  task automatic cpu_read(input logic [2:0] addr, output logic [15:0] data);
    @(negedge clk);
    spi_select = 1'b1; read_n = 1'b0; mem_addr = addr;
    @(negedge clk);
    @(negedge clk);
    data = data_to_cpu;
    spi_select = 1'b0; read_n = 1'b1;
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ss_low();
    @(negedge clk);
    SS_n = 1'b0;
    wait_clk(10);
  endtask

  task automatic ss_high();
    wait_clk(10);
    SS_n = 1'b1;
    wait_clk(10);
  endtask

  // Master shifts out the top n bits of tx, sampling MISO at each SCLK rise.
  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'd0;
    for (int i = 7; i > 7 - n; i--) begin
      MOSI = tx[i];
      wait_clk(10);
      SCLK = 1'b1;
      rx = {rx[6:0], MISO};
      wait_clk(10);
      SCLK = 1'b0;
    end
  endtask

  logic [15:0] rd;
  logic [7:0]  rx;

  initial begin
    // Reset, then abort a frame in progress with a second reset.
    wait_clk(4);
    reset_n = 1'b1;
    wait_clk(4);
    cpu_write(3'd1, 16'h0055);
    ss_low();
    spi_bits(8'hFF, 3, rx);
    reset_n = 1'b0;
    SS_n = 1'b1;
    SCLK = 1'b0;
    wait_clk(3);
    check("rst_miso", {15'd0, MISO}, 16'h0000);
    check("rst_irq", {15'd0, irq}, 16'h0000);
    check("rst_dout", data_to_cpu, 16'h0000);
    check("rst_davail", {15'd0, dataavailable}, 16'h0000);
    check("rst_rfd", {15'd0, readyfordata}, 16'h0001);
    reset_n = 1'b1;
    wait_clk(5);
    cpu_read(3'd2, rd);
    check("rst_status", rd, 16'h0060);

    // Single frame with RRDY interrupt enabled.
    cpu_write(3'd3, 16'h0080);
    cpu_read(3'd3, rd);
    check("ctrl_rb", rd, 16'h0080);
    cpu_write(3'd1, 16'h003C);
    check("primed_rfd", {15'd0, readyfordata}, 16'h0000);
    ss_low();
    spi_bits(8'hA5, 8, rx);
    wait_clk(2);
    check("single_miso", {8'd0, rx}, 16'h003C);
    check("single_irq", {15'd0, irq}, 16'h0001);
    check("single_davail", {15'd0, dataavailable}, 16'h0001);
    ss_high();
    cpu_read(3'd2, rd);
    check("single_status", rd, 16'h00E0);
    cpu_read(3'd0, rd);
    check("single_rx", rd, 16'h00A5);
    wait_clk(2);
    check("single_irq_clr", {15'd0, irq}, 16'h0000);
    check("single_davail_clr", {15'd0, dataavailable}, 16'h0000);
    cpu_write(3'd3, 16'h0000);

    // Back-to-back bytes under one select.
    cpu_write(3'd1, 16'h0011);
    ss_low();
    cpu_write(3'd1, 16'h0022);
    spi_bits(8'h81, 8, rx);
    check("b2b_miso0", {8'd0, rx}, 16'h0011);
    cpu_read(3'd0, rd);
    check("b2b_rx0", rd, 16'h0081);
    spi_bits(8'h7E, 8, rx);
    check("b2b_miso1", {8'd0, rx}, 16'h0022);
    cpu_read(3'd0, rd);
    check("b2b_rx1", rd, 16'h007E);
    ss_high();
    cpu_read(3'd2, rd);
    check("b2b_status", rd, 16'h0060);

    // Receive overrun, error interrupt, status-write clear.
    cpu_write(3'd3, 16'h0100);
    ss_low();
    spi_bits(8'h01, 8, rx);
    spi_bits(8'h02, 8, rx);
    ss_high();
    check("ovr_irq", {15'd0, irq}, 16'h0001);
    cpu_read(3'd2, rd);
    check("ovr_status", rd, 16'h01E8);
    cpu_read(3'd0, rd);
    check("ovr_rx", rd, 16'h0002);
    cpu_write(3'd2, 16'h0000);
    cpu_read(3'd2, rd);
    check("ovr_clr_status", rd, 16'h0060);
    check("ovr_clr_irq", {15'd0, irq}, 16'h0000);
    cpu_write(3'd3, 16'h0000);

    // Transmit overrun keeps the first byte; then an unprimed frame sends zeros.
    cpu_write(3'd1, 16'h005A);
    cpu_write(3'd1, 16'h0099);
    cpu_read(3'd2, rd);
    check("toe_status", rd, 16'h0110);
    ss_low();
    spi_bits(8'h00, 8, rx);
    ss_high();
    check("toe_keep_first", {8'd0, rx}, 16'h005A);
    cpu_write(3'd2, 16'h0000);
    cpu_read(3'd2, rd);
    check("toe_clr_status", rd, 16'h0060);
    ss_low();
    spi_bits(8'hF0, 8, rx);
    ss_high();
    check("udr_miso", {8'd0, rx}, 16'h0000);
    cpu_read(3'd0, rd);
    check("udr_rx", rd, 16'h00F0);

    // Aborted partial frame, then a clean frame.
    ss_low();
    spi_bits(8'hFF, 3, rx);
    ss_high();
    check("abort_davail", {15'd0, dataavailable}, 16'h0000);
    cpu_read(3'd0, rd);
    check("abort_rx", rd, 16'h00F0);
    ss_low();
    spi_bits(8'hC3, 8, rx);
    ss_high();
    check("resume_davail", {15'd0, dataavailable}, 16'h0001);
    cpu_read(3'd0, rd);
    check("resume_rx", rd, 16'h00C3);
    cpu_read(3'd4, rd);
    check("addr4_zero", rd, 16'h0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
